// File: rtl/mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module  : mem_wb_stage
// Purpose : MEM-stage data-memory access (req/ack, timeout) and MEM/WB register
// Revision: 1.0
// ============================================================================
module mem_wb_stage #(
  parameter int DM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_M,
  input  logic        flush_M,
  input  logic [31:0] IR_M,
  input  logic [31:0] PC4_M,
  input  logic [31:0] AO_M,
  input  logic [31:0] RT_M,
  input  logic [3:0]  mem_op_M,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  output logic        stall_M,
  output logic        valid_W,
  output logic [31:0] IR_W,
  output logic [31:0] PC4_W,
  output logic [31:0] AO_W,
  output logic [31:0] DR_W,
  output logic [1:0]  exc_W
);

  localparam logic [7:0] c_timeout = 8'(DM_TIMEOUT);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t     r_state;
  logic [7:0] r_cnt;
  logic       r_flushed;

  logic       w_byte, w_half, w_word;
  logic       w_load, w_store, w_memop, w_misalign, w_live, w_active;
  logic       w_timeout, w_kill;
  logic       w_wload, w_drload;
  logic [1:0] w_exc;

  always_comb begin
    w_byte = 1'b0;
    w_half = 1'b0;
    w_word = 1'b0;
    case (mem_op_M)
      4'd1, 4'd2, 4'd6: w_byte = 1'b1;
      4'd3, 4'd4, 4'd7: w_half = 1'b1;
      4'd5, 4'd8:       w_word = 1'b1;
      default:          ;
    endcase
  end

  assign w_load     = (mem_op_M >= 4'd1) && (mem_op_M <= 4'd5);
  assign w_store    = (mem_op_M >= 4'd6) && (mem_op_M <= 4'd8);
  assign w_memop    = w_load | w_store;
  assign w_misalign = (w_half & AO_M[0]) | (w_word & (|AO_M[1:0]));
  assign w_live     = valid_M & ~flush_M;
  assign w_active   = w_live & w_memop & ~w_misalign;
  assign w_timeout  = (r_cnt == c_timeout);
  // A flush in the completing cycle counts the same as an earlier one
  assign w_kill     = r_flushed | flush_M;

  always_comb begin
    dm_be    = 4'b0000;
    dm_wdata = RT_M;
    if (w_byte) begin
      dm_be    = 4'b0001 << AO_M[1:0];
      dm_wdata = {4{RT_M[7:0]}};
    end else if (w_half) begin
      dm_be    = AO_M[1] ? 4'b1100 : 4'b0011;
      dm_wdata = {2{RT_M[15:0]}};
    end else if (w_word) begin
      dm_be    = 4'b1111;
    end
  end

  assign dm_addr = {AO_M[31:2], 2'b00};
  assign dm_we   = w_store;
  assign dm_req  = rst_n & ((r_state == S_IDLE) ? w_active : ~w_timeout);
  assign stall_M = (r_state == S_IDLE) ? (w_active & ~dm_ack) : ~(dm_ack | w_timeout);

  always_comb begin
    w_wload  = 1'b0;
    w_drload = 1'b0;
    w_exc    = 2'b00;
    if (r_state == S_IDLE) begin
      if (w_active) begin
        w_wload  = dm_ack;
        w_drload = dm_ack & w_load;
      end else if (w_live) begin
        w_wload = 1'b1;
        if (w_memop) w_exc = w_store ? 2'b10 : 2'b01;
      end
    end else if (dm_ack) begin
      w_wload  = ~w_kill;
      w_drload = ~w_kill & w_load;
    end else if (w_timeout) begin
      w_wload = ~w_kill;
      w_exc   = 2'b11;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= 8'd0;
      r_flushed <= 1'b0;
      valid_W   <= 1'b0;
      IR_W      <= 32'd0;
      PC4_W     <= 32'd0;
      AO_W      <= 32'd0;
      DR_W      <= 32'd0;
      exc_W     <= 2'b00;
    end else begin
      if (r_state == S_IDLE) begin
        r_flushed <= 1'b0;
        if (w_active && !dm_ack) begin
          r_state <= S_WAIT;
          r_cnt   <= 8'd1;
        end
      end else if (dm_ack || w_timeout) begin
        r_state   <= S_IDLE;
        r_cnt     <= 8'd0;
        r_flushed <= 1'b0;
      end else begin
        r_cnt <= r_cnt + 8'd1;
        if (flush_M) r_flushed <= 1'b1;
      end

      // Every non-retiring cycle presents a bubble; IR_W=0 is a NOP
      valid_W <= w_wload;
      IR_W    <= w_wload ? IR_M  : 32'd0;
      PC4_W   <= w_wload ? PC4_M : 32'd0;
      AO_W    <= w_wload ? AO_M  : 32'd0;
      exc_W   <= w_wload ? w_exc : 2'b00;
      if (w_drload) DR_W <= dm_rdata;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_wb_stage
// Purpose : Scoreboard bench for mem_wb_stage with a random-latency memory
// Revision: 1.0
// ============================================================================
module tb_mem_wb_stage;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_M, flush_M;
  logic [31:0] IR_M, PC4_M, AO_M, RT_M;
  logic [3:0]  mem_op_M;
  logic        dm_req, dm_we, dm_ack;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic [3:0]  dm_be;
  logic        stall_M, valid_W;
  logic [31:0] IR_W, PC4_W, AO_W, DR_W;
  logic [1:0]  exc_W;

  always #5 clk = ~clk;

  mem_wb_stage #(.DM_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .valid_M(valid_M), .flush_M(flush_M),
    .IR_M(IR_M), .PC4_M(PC4_M), .AO_M(AO_M), .RT_M(RT_M), .mem_op_M(mem_op_M),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be),
    .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .stall_M(stall_M), .valid_W(valid_W), .IR_W(IR_W), .PC4_W(PC4_W),
    .AO_W(AO_W), .DR_W(DR_W), .exc_W(exc_W)
  );

  typedef struct {
    logic [31:0] ir, pc4, ao, dr;
    logic [1:0]  exc;
  } exp_t;

  exp_t        sbq[$];
  exp_t        mon_e;
  int          tests = 0;
  int          fails = 0;
  logic [31:0] last_dr = 32'd0;
  int          lat = 0;
  bit          no_ack = 1'b0;
  int          waited = 0;

  function automatic logic [31:0] memword(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'hC3A55A3C;
  endfunction

  function automatic int opsize(input logic [3:0] op);
    case (op)
      4'd1, 4'd2, 4'd6: return 1;
      4'd3, 4'd4, 4'd7: return 2;
      4'd5, 4'd8:       return 4;
      default:          return 0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Memory: acks after 'lat' extra request cycles unless no_ack is set
  always @(negedge clk) begin
    if (dm_req && !no_ack) begin
      if (waited >= lat) begin
        dm_ack   = 1'b1;
        dm_rdata = memword(dm_addr);
        waited   = 0;
      end else begin
        dm_ack   = 1'b0;
        dm_rdata = $urandom;
        waited++;
      end
    end else begin
      dm_ack = 1'b0;
      waited = 0;
    end
  end

  // Monitor: every retiring W slot must match the oldest expectation
  always @(posedge clk) begin
    #1;
    if (rst_n && valid_W) begin
      if (sbq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_retire: got IR_W=%h, required no retirement", IR_W);
      end else begin
        mon_e = sbq.pop_front();
        chk("IR_W", IR_W, mon_e.ir);
        chk("PC4_W", PC4_W, mon_e.pc4);
        chk("AO_W", AO_W, mon_e.ao);
        chk("DR_W", DR_W, mon_e.dr);
        chk("exc_W", {30'd0, exc_W}, {30'd0, mon_e.exc});
      end
    end
  end

  task automatic issue(input bit v, input bit fl, input logic [3:0] op,
                       input logic [31:0] ir, input logic [31:0] pc4,
                       input logic [31:0] ao, input logic [31:0] rt, input int l,
                       output int stalls, output int reqs);
    int          sz;
    bit          mis, act, s, done;
    exp_t        e;
    logic [63:0] m, wd;
    logic [3:0]  be;
    sz  = opsize(op);
    mis = (sz != 0) && ((ao % sz) != 0);
    act = v && !fl && (sz != 0) && !mis;
    lat = l;
    valid_M = v; flush_M = fl; mem_op_M = op;
    IR_M = ir; PC4_M = pc4; AO_M = ao; RT_M = rt;
    if (v && !fl) begin
      e.ir = ir; e.pc4 = pc4; e.ao = ao; e.exc = 2'd0;
      if (mis) e.exc = (op >= 4'd6) ? 2'd2 : 2'd1;
      else if (act && no_ack) e.exc = 2'd3;
      else if (act && op <= 4'd5) last_dr = memword(ao - (ao % 4));
      e.dr = last_dr;
      sbq.push_back(e);
    end
    be = 4'd0; wd = 64'd0;
    if (sz != 0) begin
      be = 4'(((1 << sz) - 1) << (((ao % 4) / sz) * sz));
      m  = (64'd1 << (8 * sz)) - 64'd1;
      for (int k = 0; k < 4 / sz; k++) wd = wd | ((64'(rt) & m) << (8 * sz * k));
    end
    stalls = 0; reqs = 0; done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk); #1;
      if (c == 0) begin
        chk("dm_req", {31'd0, dm_req}, {31'd0, act});
        if (act) begin
          chk("dm_addr", dm_addr, ao - (ao % 4));
          chk("dm_be", {28'd0, dm_be}, {28'd0, be});
          chk("dm_we", {31'd0, dm_we}, {31'd0, op >= 4'd6});
          if (op >= 4'd6) chk("dm_wdata", dm_wdata, wd[31:0]);
        end
      end
      if (dm_req) reqs++;
      s = stall_M;
      @(posedge clk); #1;
      if (!s) done = 1'b1;
      else stalls++;
    end
    if (!done) chk("stall_bound", 32'd1, 32'd0);
  endtask

  initial begin
    int st, rq;
    valid_M = 0; flush_M = 0; mem_op_M = 0; IR_M = 0; PC4_M = 0; AO_M = 0; RT_M = 0;
    dm_ack = 0; dm_rdata = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dm_req", {31'd0, dm_req}, 32'd0);
    chk("rst_valid_W", {31'd0, valid_W}, 32'd0);
    chk("rst_IR_W", IR_W, 32'd0);
    chk("rst_DR_W", DR_W, 32'd0);
    chk("rst_exc_W", {30'd0, exc_W}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    issue(1, 0, 4'd1, 32'h80001003, 32'h404, 32'h1003, 32'h0, 0, st, rq);
    chk("lb_stalls", st, 0);
    issue(1, 0, 4'd7, 32'hA4002002, 32'h408, 32'h2002, 32'h1234BEEF, 3, st, rq);
    chk("sh_stalls", st, 3);
    issue(1, 0, 4'd5, 32'h8C000006, 32'h40C, 32'h6, 32'h0, 0, st, rq);
    chk("lw_mis_req", rq, 0);
    issue(1, 0, 4'd8, 32'hAC000001, 32'h410, 32'h1, 32'h55, 0, st, rq);
    chk("sw_mis_req", rq, 0);

    no_ack = 1'b1;
    issue(1, 0, 4'd5, 32'h8C000040, 32'h414, 32'h40, 32'h0, 0, st, rq);
    chk("to_req_cycles", rq, TO);
    chk("to_stalls", st, TO);
    no_ack = 1'b0;

    // Flush while waiting: transfer completes, W stays empty
    lat = 2;
    valid_M = 1; flush_M = 0; mem_op_M = 4'd5; IR_M = 32'h8C000080; AO_M = 32'h80;
    @(posedge clk); #1;
    flush_M = 1'b1;
    @(posedge clk); #1;
    flush_M = 1'b0;
    @(negedge clk); #1;
    chk("fl_ack", {31'd0, dm_ack}, 32'd1);
    chk("fl_stall", {31'd0, stall_M}, 32'd0);
    @(posedge clk); #1;
    chk("fl_valid_W", {31'd0, valid_W}, 32'd0);
    chk("fl_IR_W", IR_W, 32'd0);
    valid_M = 0;

    issue(1, 0, 4'd0, 32'h00851021, 32'h500, 32'h9, 32'h0, 0, st, rq);
    chk("b2b_addu_st", st, 0);
    issue(1, 0, 4'd5, 32'h8C000100, 32'h504, 32'h100, 32'h0, 0, st, rq);
    chk("b2b_lw_st", st, 0);
    issue(1, 0, 4'd6, 32'hA0000101, 32'h508, 32'h101, 32'h77, 0, st, rq);
    chk("b2b_sb_st", st, 0);

    for (int i = 0; i < 200; i++) begin
      issue(($urandom_range(0, 9) != 0), ($urandom_range(0, 9) == 0),
            4'($urandom_range(0, 15)), $urandom, $urandom, $urandom, $urandom,
            $urandom_range(0, TO - 1), st, rq);
    end

    // Reset in the middle of a wait abandons the access
    no_ack = 1'b1;
    valid_M = 1; flush_M = 0; mem_op_M = 4'd5; IR_M = 32'h8C000200; AO_M = 32'h200;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rw_req_before", {31'd0, dm_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rw_dm_req", {31'd0, dm_req}, 32'd0);
    chk("rw_valid_W", {31'd0, valid_W}, 32'd0);
    chk("rw_IR_W", IR_W, 32'd0);
    chk("rw_PC4_W", PC4_W, 32'd0);
    chk("rw_AO_W", AO_W, 32'd0);
    chk("rw_DR_W", DR_W, 32'd0);
    chk("rw_exc_W", {30'd0, exc_W}, 32'd0);
    last_dr = 32'd0;
    valid_M = 0;
    no_ack = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    issue(1, 0, 4'd2, 32'h90000203, 32'h600, 32'h203, 32'h0, 1, st, rq);
    chk("post_rst_st", st, 1);
    valid_M = 0;
    repeat (3) @(posedge clk);
    #2;
    chk("sb_drain", sbq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- MEM-stage data-memory access unit and MEM/WB pipeline register of the 5-stage MIPS pipeline.
- Issues loads and stores to a variable-latency data memory over a req/ack handshake.
- Stalls the pipeline while an access is outstanding and delivers the instruction's results to the write-back stage registers.
- Also generates byte enables, store-data lane steering, alignment exceptions and a bus-timeout exception.

Parameters:
- DM_TIMEOUT, 255: max WAIT cycles without dm_ack before abort; range 1..255.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- valid_M  in  1  M-stage slot holds a real instruction
- flush_M  in  1  kill the M-stage instruction
- IR_M  in  32  instruction in M
- PC4_M  in  32  PC+4 of instruction in M
- AO_M  in  32  ALU result; effective address for memory ops
- RT_M  in  32  store data (forwarded rt)
- mem_op_M  in  4  0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW; 9-15 treated as none
- dm_req  out  1  memory request
- dm_we  out  1  1 = write
- dm_addr  out  32  {AO_M[31:2],2'b00}
- dm_be  out  4  byte enables, bit i = byte lane i (little-endian)
- dm_wdata  out  32  lane-steered store data
- dm_ack  in  1  access complete; dm_rdata valid in the same cycle for reads
- dm_rdata  in  32  read word
- stall_M  out  1  hold IF/ID/EX/M registers
- valid_W  out  1  W slot holds a real instruction
- IR_W, PC4_W, AO_W  out  32 each  registered copies
- DR_W  out  32  raw read word (write-back stage extracts and extends)
- exc_W  out  2  00 none, 01 AdEL, 10 AdES, 11 bus timeout

Behaviour:
- States: IDLE, WAIT. Reset (rst_n=0, async) forces:
  - state IDLE, timeout counter 0;
  - all W outputs 0 (IR_W=0 is a NOP);
  - dm_req gated to 0 while rst_n=0.
- Alignment:
  - SH/LH/LHU misaligned if AO_M[0]=1.
  - SW/LW misaligned if AO_M[1:0]!=0.
  - LB/LBU/SB never misaligned.
- Byte enables:
  - byte ops: 4'b0001<<AO_M[1:0];
  - half ops: AO_M[1] ? 4'b1100 : 4'b0011;
  - word ops: 4'b1111.
- dm_wdata: SB → {4{RT_M[7:0]}}; SH → {2{RT_M[15:0]}}; SW → RT_M.
- "Active" = valid_M & !flush_M & mem_op in 1..8 & aligned.
- IDLE:
  - dm_req = active (combinational). dm_we = store op. stall_M = active & !dm_ack.
  - Active & dm_ack (zero-wait): W registers load IR/PC4/AO from M, DR_W=dm_rdata (loads; stores: unchanged), valid_W=1, exc_W=00; stay IDLE.
  - Active & !dm_ack: go to WAIT, counter=1; W loads bubble (valid_W=0, IR_W=0).
  - Misaligned valid op (not flushed): no request; W loads instruction with valid_W=1, exc_W=01 (load) / 10 (store).
  - Non-memory valid op: one-cycle pass-through, no request, exc_W=00.
  - flush_M or !valid_M: W loads bubble.
- WAIT:
  - dm_req=1. Address, be, we, wdata stable (M held by stall_M=1).
  - dm_ack: W loads the result as above; next state IDLE; stall_M=0 in that cycle.
  - If flush_M was seen while in WAIT (sticky flag), the ack completes the bus transfer but W loads a bubble; the flag clears.
  - No ack and counter==DM_TIMEOUT: drop dm_req, W loads instruction with valid_W=1, exc_W=11; go to IDLE; stall_M=0.
  - Otherwise counter+1 (8-bit, never wraps before the timeout).
- The request is never withdrawn before ack, except by timeout or reset.
- A late dm_ack arriving in IDLE with no active request is ignored.
- Reset mid-WAIT abandons the access; the memory side must tolerate req dropping.
- Back-to-back memory ops: after an ack the next op may request in the following cycle; no idle gap is required.

Test Plan:
- LB, AO_M=0x1003, dm_ack same cycle, dm_rdata=0xAABBCCDD → dm_be=1000, dm_addr=0x1000, stall_M=0, next cycle DR_W=0xAABBCCDD, valid_W=1, exc_W=00.
- SH, AO_M=0x2002, RT_M=0x1234BEEF, ack after 3 cycles → dm_we=1, dm_be=1100, dm_wdata=0xBEEFBEEF; stall_M high 3 cycles; valid_W=0 during wait, 1 after ack.
- LW, AO_M=0x0006 → no dm_req; next cycle exc_W=01, valid_W=1. SW, AO_M=0x0001 → exc_W=10.
- DM_TIMEOUT=4, LW with no ack → dm_req high 4 cycles then low; exc_W=11; stall_M released.
- LW waiting, flush_M pulsed in cycle 2, ack in cycle 3 → valid_W=0, IR_W=0. Separately, rst_n low mid-WAIT → dm_req=0 immediately; all W outputs 0.
- ADDU then LW then SB back-to-back with zero-wait acks → three consecutive valid_W cycles, correct IR_W sequence, no stalls.
